// File: rtl/query_enum_pkg.sv
// Shared types and width helpers for the query enumerator and its predicate.
package query_enum_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Default operand width and the widths derived from it.
  localparam int Q_WIDTH = 3;
  localparam int Q_IDX_W = 2 * Q_WIDTH;      // {b, a} index
  localparam int Q_CNT_W = 2 * Q_WIDTH + 1;  // can hold 2^(2W) solutions

  // One solution record at the default width.
  typedef struct packed {
    logic [Q_WIDTH-1:0] a;
    logic [Q_WIDTH-1:0] b;
  } solution_t;

  // Index register width for an arbitrary operand width.
  function automatic int idx_width(input int w);
    return 2 * w;
  endfunction

  // Solution counter width: one extra bit so every pair may be a solution.
  function automatic int cnt_width(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/query_enumerator_fours_check.sv
// Combinational "fours" predicate: (a+b) mod 2^W == T and (a*b) mod 2^W == T.
// Kept as its own block so another query predicate can be dropped in.
module fours_check #(
  parameter int WIDTH  = 3,
  parameter int TARGET = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_ok
);

  // Target truncated to the operand width, matching the modular arithmetic.
  localparam logic [WIDTH-1:0] TGT = WIDTH'(TARGET);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_prod;

  // Both results are sized to WIDTH, so the carry / high product bits drop off.
  assign w_sum  = i_a + i_b;
  assign w_prod = i_a * i_b;
  assign o_ok   = (w_sum == TGT) && (w_prod == TGT);

endmodule

// File: rtl/query_enumerator.sv
// Brute-force sweep of every (A, B) pair through the query predicate.
// Satisfying pairs are queued in a small FIFO and streamed out over
// valid/ready. When the FIFO is full the sweep stalls on the matching index.
module query_enumerator
  import query_enum_pkg::*;
#(
  parameter int WIDTH      = Q_WIDTH,
  parameter int TARGET     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               sol_valid,
  input  logic               sol_ready,
  output logic [WIDTH-1:0]   sol_a,
  output logic [WIDTH-1:0]   sol_b,
  output logic [2*WIDTH:0]   sol_count
);

  localparam int IDX_W = idx_width(WIDTH);
  localparam int CNT_W = cnt_width(WIDTH);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  // FIFO entry at this instance's operand width.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } entry_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t           r_state;
  logic [IDX_W-1:0] r_index;
  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic             r_done;

  entry_t           r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;

  // ---------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_ok;
  logic             w_scan;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_advance;
  logic             w_last;
  entry_t           w_head;

  // a is the inner loop (low bits), b the outer loop (high bits).
  assign w_a = r_index[WIDTH-1:0];
  assign w_b = r_index[IDX_W-1:WIDTH];

  fours_check #(
    .WIDTH  (WIDTH),
    .TARGET (TARGET)
  ) u_check (
    .i_a  (w_a),
    .i_b  (w_b),
    .o_ok (w_ok)
  );

  assign w_scan  = (r_state == SCAN);
  assign w_empty = (r_occ == '0);
  // Registered occupancy only: a pop this cycle does not make room for a
  // push this cycle, which keeps the full flag off the ready path.
  assign w_full  = (r_occ == OCC_FULL);
  assign w_push  = w_scan && w_ok && !w_full;
  // A match that cannot be queued holds the index and retries next cycle.
  assign w_advance = w_scan && (!w_ok || !w_full);
  assign w_last  = &r_index;
  assign w_pop   = sol_valid && sol_ready;

  // Circular pointer step that also works for non-power-of-two pointer ranges.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------
  // Sweep controller
  // ---------------------------------------------------------------------
  // Walks the index through SCAN, waits out the FIFO in DRAIN, parks in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_index <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= SCAN;
            r_index <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        SCAN: begin
          if (w_push) begin
            r_count <= r_count + 1'b1;
          end
          if (w_advance) begin
            // The index wraps to zero on the last step but is not evaluated again.
            r_index <= r_index + 1'b1;
            if (w_last) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_empty) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Solution FIFO
  // ---------------------------------------------------------------------
  // Pointer and occupancy bookkeeping; reset discards any queued solutions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Storage array; no reset so it can map onto distributed/block memory.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_a, w_b};
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign w_head    = r_mem[r_rd_ptr];
  assign sol_valid = !w_empty;
  // Head data is forced to zero while nothing is queued, so reset shows zeros.
  assign sol_a     = sol_valid ? w_head.a : '0;
  assign sol_b     = sol_valid ? w_head.b : '0;
  assign sol_count = r_count;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
